// File: rtl/arb_mux_n.sv
// N-channel arbitrating multiplexer with a single registered output entry.
// Round-robin (MODE 0) or lowest-index fixed priority (MODE 1) grant, valid/ready on every port.
module arb_mux_n #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int MODE  = 0,
    localparam int SW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic [SW-1:0]      out_sel,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SW-1:0]    ptr;
    logic [SW-1:0]    start;
    logic [SW-1:0]    grant_idx;
    logic [SW-1:0]    ptr_next;
    logic [N-1:0]     grant;
    logic [WIDTH-1:0] grant_data;
    logic             found;
    logic             can_accept;
    logic             fire_in;

    function automatic int wrap_add(input int base, input int off);
        int s;
        s = base + off;
        return (s >= N) ? s - N : s;
    endfunction

    assign start = (MODE == 0) ? ptr : '0;

    // Scan priority slots k = 0..N-1 starting at 'start'; first valid channel wins.
    always_comb begin
        grant      = '0;
        grant_idx  = '0;
        grant_data = '0;
        found      = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && in_valid[i] && (i == wrap_add(int'(start), k))) begin
                    found      = 1'b1;
                    grant[i]   = 1'b1;
                    grant_idx  = SW'(i);
                    grant_data = in_data[i*WIDTH +: WIDTH];
                end
            end
        end
    end

    assign can_accept = !out_valid || out_ready;
    assign in_ready   = (rst || !can_accept) ? '0 : grant;
    assign fire_in    = found && can_accept && !rst;
    assign ptr_next   = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + SW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= '0;
            ptr       <= '0;
        end else begin
            if (fire_in) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_sel   <= grant_idx;
                if (MODE == 0) begin
                    ptr <= ptr_next;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_arb_mux_n.sv
// Self-checking bench for arb_mux_n: directed scenarios plus a randomized run against
// a slot-scanning reference model of the grant rules.
module tb_arb_mux_n;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [127:0] in_data = '0;
    logic [3:0]   in_valid = '0;
    logic         out_ready = 1'b0;

    logic [3:0]   rr_ready, fp_ready;
    logic [31:0]  rr_data, fp_data;
    logic [1:0]   rr_sel, fp_sel;
    logic         rr_valid, fp_valid;

    logic [95:0]  n3_in_data = '0;
    logic [2:0]   n3_in_valid = '0;
    logic         n3_out_ready = 1'b0;
    logic [2:0]   n3_ready;
    logic [31:0]  n3_data;
    logic [1:0]   n3_sel;
    logic         n3_valid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    arb_mux_n #(.WIDTH(32), .N(4), .MODE(0)) dut_rr (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(rr_ready),
        .out_data(rr_data), .out_sel(rr_sel), .out_valid(rr_valid), .out_ready(out_ready));

    arb_mux_n #(.WIDTH(32), .N(4), .MODE(1)) dut_fp (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(fp_ready),
        .out_data(fp_data), .out_sel(fp_sel), .out_valid(fp_valid), .out_ready(out_ready));

    arb_mux_n #(.WIDTH(32), .N(3), .MODE(0)) dut_n3 (
        .clk(clk), .rst(rst), .in_data(n3_in_data), .in_valid(n3_in_valid), .in_ready(n3_ready),
        .out_data(n3_data), .out_sel(n3_sel), .out_valid(n3_valid), .out_ready(n3_out_ready));

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    task automatic set_ch(input int i, input logic [31:0] v);
        in_data[i*32 +: 32] = v;
    endtask

    task automatic test_reset();
        in_valid = 4'b1111;
        tick();
        n_cmp++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL reset_ready got %b want 0000", rr_ready); end
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", rr_valid); end
        n_cmp++; if (rr_data !== 32'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", rr_data); end
        n_cmp++; if (rr_sel !== 2'd0) begin n_bad++; $display("FAIL reset_sel got %0d want 0", rr_sel); end
        rst = 1'b0;
        in_valid = 4'b0001;
        set_ch(0, 32'h1111_1111);
        out_ready = 1'b0;
        tick();
        n_cmp++; if (rr_valid !== 1'b1 || rr_data !== 32'h1111_1111) begin n_bad++; $display("FAIL pre_reset_load got %b/%h want 1/11111111", rr_valid, rr_data); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL async_reset_valid got %b want 0", rr_valid); end
        n_cmp++; if (rr_data !== 32'h0) begin n_bad++; $display("FAIL async_reset_data got %h want 0", rr_data); end
        n_cmp++; if (rr_sel !== 2'd0) begin n_bad++; $display("FAIL async_reset_sel got %0d want 0", rr_sel); end
        n_cmp++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL async_reset_ready got %b want 0000", rr_ready); end
        #1 rst = 1'b0;
        set_ch(0, 32'hA5A5_A5A5);
        out_ready = 1'b1;
        #1;
        n_cmp++; if (rr_ready !== 4'b0001) begin n_bad++; $display("FAIL post_reset_ready got %b want 0001", rr_ready); end
        tick();
        n_cmp++; if (rr_valid !== 1'b1 || rr_data !== 32'hA5A5_A5A5 || rr_sel !== 2'd0) begin
            n_bad++; $display("FAIL post_reset_word got %b/%h/%0d want 1/a5a5a5a5/0", rr_valid, rr_data, rr_sel); end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL drain_valid got %b want 0", rr_valid); end
    endtask

    task automatic test_round_robin();
        do_reset();
        in_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_ch(i, 32'h100 + i);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            n_cmp++; if (rr_ready !== 4'(1 << (c % 4))) begin n_bad++; $display("FAIL rr_ready[%0d] got %b want %b", c, rr_ready, 4'(1 << (c % 4))); end
            tick();
            n_cmp++; if (rr_valid !== 1'b1 || rr_sel !== 2'(c % 4) || rr_data !== 32'(32'h100 + c % 4)) begin
                n_bad++; $display("FAIL rr_word[%0d] got %b/%0d/%h want 1/%0d/%h", c, rr_valid, rr_sel, rr_data, c % 4, 32'h100 + c % 4); end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        set_ch(0, 32'h11);
        set_ch(1, 32'h22);
        in_valid = 4'b0011;
        out_ready = 1'b1;
        tick();
        n_cmp++; if (rr_data !== 32'h11 || rr_sel !== 2'd0) begin n_bad++; $display("FAIL bp_first got %h/%0d want 11/0", rr_data, rr_sel); end
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL bp_stall_ready[%0d] got %b want 0000", c, rr_ready); end
            tick();
            n_cmp++; if (rr_valid !== 1'b1 || rr_data !== 32'h11 || rr_sel !== 2'd0) begin
                n_bad++; $display("FAIL bp_hold[%0d] got %b/%h/%0d want 1/11/0", c, rr_valid, rr_data, rr_sel); end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++; if (rr_ready !== 4'b0010) begin n_bad++; $display("FAIL bp_release_ready got %b want 0010", rr_ready); end
        tick();
        n_cmp++; if (rr_valid !== 1'b1 || rr_data !== 32'h22 || rr_sel !== 2'd1) begin
            n_bad++; $display("FAIL bp_next got %b/%h/%0d want 1/22/1", rr_valid, rr_data, rr_sel); end
        in_valid = 4'b0000;
        tick();
        n_cmp++; if (rr_valid !== 1'b0 || rr_data !== 32'h22) begin n_bad++; $display("FAIL bp_drain got %b/%h want 0/22", rr_valid, rr_data); end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        for (int i = 0; i < 4; i++) set_ch(i, 32'h200 + i);
        in_valid = 4'b1110;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_cmp++; if (fp_ready !== 4'b0010) begin n_bad++; $display("FAIL fp_ready[%0d] got %b want 0010", c, fp_ready); end
            tick();
            n_cmp++; if (fp_valid !== 1'b1 || fp_sel !== 2'd1 || fp_data !== 32'h201) begin
                n_bad++; $display("FAIL fp_word[%0d] got %b/%0d/%h want 1/1/201", c, fp_valid, fp_sel, fp_data); end
        end
        in_valid = 4'b1100;
        #1;
        n_cmp++; if (fp_ready !== 4'b0100) begin n_bad++; $display("FAIL fp_drop_ready got %b want 0100", fp_ready); end
        tick();
        n_cmp++; if (fp_sel !== 2'd2 || fp_data !== 32'h202) begin n_bad++; $display("FAIL fp_drop_word got %0d/%h want 2/202", fp_sel, fp_data); end
        in_valid = 4'b0000;
        tick();
    endtask

    task automatic test_n3_wrap();
        do_reset();
        for (int i = 0; i < 3; i++) n3_in_data[i*32 +: 32] = 32'h300 + i;
        n3_in_valid = 3'b101;
        n3_out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            int e;
            e = (c % 2 == 1) ? 2 : 0;
            #1;
            n_cmp++; if (n3_ready !== 3'(1 << e)) begin n_bad++; $display("FAIL n3_ready[%0d] got %b want %b", c, n3_ready, 3'(1 << e)); end
            tick();
            n_cmp++; if (n3_valid !== 1'b1 || n3_sel !== 2'(e) || n3_data !== 32'(32'h300 + e)) begin
                n_bad++; $display("FAIL n3_word[%0d] got %b/%0d/%h want 1/%0d/%h", c, n3_valid, n3_sel, n3_data, e, 32'h300 + e); end
            n_cmp++; if (dut_n3.ptr > 2'd2) begin n_bad++; $display("FAIL n3_ptr[%0d] got %0d want <3", c, dut_n3.ptr); end
        end
        n3_in_valid = 3'b000;
        tick();
    endtask

    task automatic test_sparse();
        do_reset();
        out_ready = 1'b1;
        set_ch(2, 32'h42);
        in_valid = 4'b0100;
        #1;
        n_cmp++; if (rr_ready !== 4'b0100) begin n_bad++; $display("FAIL sp_ready2 got %b want 0100", rr_ready); end
        tick();
        in_valid = 4'b0000;
        n_cmp++; if (rr_valid !== 1'b1 || rr_sel !== 2'd2 || rr_data !== 32'h42) begin
            n_bad++; $display("FAIL sp_word2 got %b/%0d/%h want 1/2/42", rr_valid, rr_sel, rr_data); end
        #1;
        n_cmp++; if (rr_ready !== 4'b0000) begin n_bad++; $display("FAIL sp_idle_ready got %b want 0000", rr_ready); end
        set_ch(0, 32'h40);
        in_valid = 4'b0001;
        #1;
        n_cmp++; if (rr_ready !== 4'b0001) begin n_bad++; $display("FAIL sp_ready0 got %b want 0001", rr_ready); end
        tick();
        in_valid = 4'b0000;
        n_cmp++; if (rr_valid !== 1'b1 || rr_sel !== 2'd0 || rr_data !== 32'h40) begin
            n_bad++; $display("FAIL sp_word0 got %b/%0d/%h want 1/0/40", rr_valid, rr_sel, rr_data); end
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if (rr_valid !== 1'b0) begin n_bad++; $display("FAIL sp_idle_valid[%0d] got %b want 0", c, rr_valid); end
        end
    endtask

    // Reference: each cycle scan priority slots from the pointer (or 0 for fixed priority).
    task automatic test_random();
        bit          mv[2];
        logic [31:0] md[2];
        int          ms[2];
        int          mp[2];
        int          g[2];
        logic [3:0]  er[2];
        logic [3:0]  ar;
        logic        av;
        logic [31:0] ad;
        logic [1:0]  as_;
        do_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0; md[m] = '0; ms[m] = 0; mp[m] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            in_valid = 4'($urandom_range(0, 15));
            for (int i = 0; i < 4; i++) set_ch(i, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            for (int m = 0; m < 2; m++) begin
                g[m] = -1;
                for (int k = 0; k < 4; k++) begin
                    int idx;
                    idx = (((m == 1) ? 0 : mp[m]) + k) % 4;
                    if (g[m] < 0 && in_valid[idx]) g[m] = idx;
                end
                er[m] = (g[m] >= 0 && (!mv[m] || out_ready)) ? 4'(1 << g[m]) : 4'b0000;
                ar = (m == 0) ? rr_ready : fp_ready;
                n_cmp++; if (ar !== er[m]) begin n_bad++; $display("FAIL rnd_ready m%0d c%0d got %b want %b", m, c, ar, er[m]); end
                n_cmp++; if ($countones(ar) > 1) begin n_bad++; $display("FAIL rnd_onehot m%0d c%0d got %b want <=1 bit", m, c, ar); end
            end
            tick();
            for (int m = 0; m < 2; m++) begin
                if (er[m] != 4'b0000) begin
                    mv[m] = 1'b1;
                    md[m] = in_data[g[m]*32 +: 32];
                    ms[m] = g[m];
                    if (m == 0) mp[m] = (g[m] + 1) % 4;
                end else if (mv[m] && out_ready) begin
                    mv[m] = 1'b0;
                end
                av  = (m == 0) ? rr_valid : fp_valid;
                ad  = (m == 0) ? rr_data : fp_data;
                as_ = (m == 0) ? rr_sel : fp_sel;
                n_cmp++; if (av !== mv[m] || ad !== md[m] || as_ !== 2'(ms[m])) begin
                    n_bad++; $display("FAIL rnd_out m%0d c%0d got %b/%h/%0d want %b/%h/%0d", m, c, av, ad, as_, mv[m], md[m], ms[m]); end
            end
        end
        in_valid = 4'b0000;
        tick();
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_backpressure();
        test_fixed_priority();
        test_n3_wrap();
        test_sparse();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
